// File: rtl/pc_seq_pkg.sv
// Shared types for the PC sequencer: run-control states, fault codes and
// the one-hot verdict produced by the next-address classifier.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISALIGN = 2'd1;
    localparam logic [1:0] FC_RANGE    = 2'd2;
    localparam logic [1:0] FC_TIMEOUT  = 2'd3;

    // Exactly one field is set after priority resolution.
    typedef struct packed {
        logic misalign;
        logic range_err;
        logic selfloop;
        logic timeout;
        logic ok;
    } verdict_t;

endpackage

// File: rtl/pc_check.sv
// Combinational classifier for the CPU's proposed next address; resolves
// misalign > out-of-range > self-jump > timeout > ok into a one-hot verdict.
module pc_check
    import pc_seq_pkg::*;
#(
    parameter int IM_BYTES   = 1024,
    parameter int MAX_RETIRE = 4096,
    parameter int CNT_W      = 32
) (
    input  logic [31:0]      next_pc,
    input  logic [31:0]      pc,
    input  logic [CNT_W-1:0] retired,
    output verdict_t         verdict
);

    localparam logic [31:0]      IM_LIMIT = 32'(IM_BYTES);
    localparam logic [CNT_W-1:0] RET_LAST = CNT_W'(MAX_RETIRE - 1);

    always_comb begin
        verdict = '0;
        if (next_pc[1:0] != 2'b00) begin
            verdict.misalign = 1'b1;
        end else if (next_pc >= IM_LIMIT) begin
            verdict.range_err = 1'b1;
        end else if (next_pc == pc) begin
            verdict.selfloop = 1'b1;
        end else if (retired == RET_LAST) begin
            // The commit happening now is the last one allowed.
            verdict.timeout = 1'b1;
        end else begin
            verdict.ok = 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter and run-control stage in front of the single-cycle CPU:
// owns the PC, commits next_pc each RUN cycle and counts retired instructions.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IM_BYTES   = 1024,
    parameter int          MAX_RETIRE = 4096,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      next_pc,
    output logic [31:0]      pc,
    output logic             cpu_en,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] retired
);

    state_t           state;
    state_t           state_nx;
    logic [31:0]      pc_nx;
    logic [CNT_W-1:0] retired_nx;
    logic [CNT_W-1:0] retired_inc;
    logic [1:0]       fault_code_nx;
    verdict_t         verdict;

    pc_check #(
        .IM_BYTES  (IM_BYTES),
        .MAX_RETIRE(MAX_RETIRE),
        .CNT_W     (CNT_W)
    ) u_check (
        .next_pc(next_pc),
        .pc     (pc),
        .retired(retired),
        .verdict(verdict)
    );

    // Saturate rather than wrap so a very long run never reads as short.
    assign retired_inc = (&retired) ? retired : retired + CNT_W'(1);

    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        retired_nx    = retired;
        fault_code_nx = fault_code;
        case (state)
            RUN: begin
                // The current instruction always commits; only its successor
                // address can be rejected.
                retired_nx = retired_inc;
                if (verdict.misalign) begin
                    state_nx      = FAULT;
                    fault_code_nx = FC_MISALIGN;
                end else if (verdict.range_err) begin
                    state_nx      = FAULT;
                    fault_code_nx = FC_RANGE;
                end else if (verdict.selfloop) begin
                    state_nx = HALT;
                end else if (verdict.timeout) begin
                    state_nx      = FAULT;
                    fault_code_nx = FC_TIMEOUT;
                end else if (verdict.ok) begin
                    pc_nx = next_pc;
                end
            end
            IDLE, HALT, FAULT: begin
                if (start) begin
                    state_nx      = RUN;
                    pc_nx         = RESET_PC;
                    retired_nx    = '0;
                    fault_code_nx = FC_NONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            retired    <= '0;
            fault_code <= FC_NONE;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            retired    <= retired_nx;
            fault_code <= fault_code_nx;
        end
    end

    assign busy   = (state == RUN);
    assign cpu_en = (state == RUN);
    assign done   = (state == HALT);
    assign fault  = (state == FAULT);

endmodule
